// File: rtl/hazard_tracker_pkg.sv
// Shared constants, forwarding encodings and stage-record types for the
// P5 hazard tracker.
package hazard_tracker_pkg;

    localparam int TNEW_W = 4;
    localparam int REG_W  = 5;

    // A tuse of all-ones marks an operand the instruction never reads.
    localparam logic [TNEW_W-1:0] TUSE_NONE = {TNEW_W{1'b1}};

    // D-side forwarding selects
    localparam logic [1:0] FWD_RF   = 2'd0;
    localparam logic [1:0] FWD_M    = 2'd1;
    localparam logic [1:0] FWD_E    = 2'd2;
    // E-side forwarding selects (0 keeps the pipeline value, 1 is FWD_M)
    localparam logic [1:0] FWD_PIPE = 2'd0;
    localparam logic [1:0] FWD_W    = 2'd2;

    typedef struct packed {
        logic [REG_W-1:0]  dst;
        logic [TNEW_W-1:0] tnew;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
    } e_stage_t;

    typedef struct packed {
        logic [REG_W-1:0]  dst;
        logic [TNEW_W-1:0] tnew;
        logic [REG_W-1:0]  rt;
    } m_stage_t;

    // Age a tnew by one stage, never wrapping below zero.
    function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

endpackage

// File: rtl/hazard_tracker_match.sv
// One source-vs-producer comparison: does this producer force a stall, or
// can its result be forwarded right now? Register 0 never matches.
module hazard_match
    import hazard_tracker_pkg::*;
(
    input  logic [REG_W-1:0]  i_src,
    input  logic [TNEW_W-1:0] i_tuse,
    input  logic [REG_W-1:0]  i_dst,
    input  logic [TNEW_W-1:0] i_tnew,
    output logic              o_stall_req,
    output logic              o_fwd_ok
);

    logic w_hit;

    assign w_hit       = (i_src != '0) && (i_dst == i_src);
    assign o_stall_req = w_hit && (i_tuse != TUSE_NONE) && (i_tnew > i_tuse);
    assign o_fwd_ok    = w_hit && (i_tnew == '0);

endmodule

// File: rtl/hazard_tracker.sv
// Shadow E/M/W hazard state for the five-stage pipeline; produces the D-stage
// stall and every forwarding select. Holds no datapath values.
module hazard_tracker
    import hazard_tracker_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  d_rs,
    input  logic [REG_W-1:0]  d_rt,
    input  logic [TNEW_W-1:0] d_tuse_rs,
    input  logic [TNEW_W-1:0] d_tuse_rt,
    input  logic [REG_W-1:0]  d_dst,
    input  logic [TNEW_W-1:0] d_tnew,
    output logic              stall,
    output logic [1:0]        fwd_d_rs,
    output logic [1:0]        fwd_d_rt,
    output logic [1:0]        fwd_e_rs,
    output logic [1:0]        fwd_e_rt,
    output logic              fwd_m_rt,
    output logic [31:0]       stall_cnt
);

    e_stage_t          r_e;
    m_stage_t          r_m;
    logic [REG_W-1:0]  r_w_dst;
    logic [31:0]       r_stall_cnt;

    logic w_stl_rs_e, w_stl_rs_m, w_stl_rt_e, w_stl_rt_m;
    logic w_fwd_rs_e, w_fwd_rs_m, w_fwd_rt_e, w_fwd_rt_m;
    logic w_fwd_ers_m, w_fwd_ers_w, w_fwd_ert_m, w_fwd_ert_w, w_fwd_mrt_w;
    // Stall requests of the downstream comparisons are meaningless (tuse is
    // TUSE_NONE there); collected here only so every pin is connected.
    logic [4:0] w_unused_stall;

    // D operands against producers in E and M: stall and D-side forwarding
    hazard_match u_rs_e (.i_src(d_rs), .i_tuse(d_tuse_rs), .i_dst(r_e.dst), .i_tnew(r_e.tnew),
                         .o_stall_req(w_stl_rs_e), .o_fwd_ok(w_fwd_rs_e));
    hazard_match u_rs_m (.i_src(d_rs), .i_tuse(d_tuse_rs), .i_dst(r_m.dst), .i_tnew(r_m.tnew),
                         .o_stall_req(w_stl_rs_m), .o_fwd_ok(w_fwd_rs_m));
    hazard_match u_rt_e (.i_src(d_rt), .i_tuse(d_tuse_rt), .i_dst(r_e.dst), .i_tnew(r_e.tnew),
                         .o_stall_req(w_stl_rt_e), .o_fwd_ok(w_fwd_rt_e));
    hazard_match u_rt_m (.i_src(d_rt), .i_tuse(d_tuse_rt), .i_dst(r_m.dst), .i_tnew(r_m.tnew),
                         .o_stall_req(w_stl_rt_m), .o_fwd_ok(w_fwd_rt_m));

    // E operands against M and W, M store data against W
    hazard_match u_ers_m (.i_src(r_e.rs), .i_tuse(TUSE_NONE), .i_dst(r_m.dst), .i_tnew(r_m.tnew),
                          .o_stall_req(w_unused_stall[0]), .o_fwd_ok(w_fwd_ers_m));
    hazard_match u_ers_w (.i_src(r_e.rs), .i_tuse(TUSE_NONE), .i_dst(r_w_dst), .i_tnew('0),
                          .o_stall_req(w_unused_stall[1]), .o_fwd_ok(w_fwd_ers_w));
    hazard_match u_ert_m (.i_src(r_e.rt), .i_tuse(TUSE_NONE), .i_dst(r_m.dst), .i_tnew(r_m.tnew),
                          .o_stall_req(w_unused_stall[2]), .o_fwd_ok(w_fwd_ert_m));
    hazard_match u_ert_w (.i_src(r_e.rt), .i_tuse(TUSE_NONE), .i_dst(r_w_dst), .i_tnew('0),
                          .o_stall_req(w_unused_stall[3]), .o_fwd_ok(w_fwd_ert_w));
    hazard_match u_mrt_w (.i_src(r_m.rt), .i_tuse(TUSE_NONE), .i_dst(r_w_dst), .i_tnew('0),
                          .o_stall_req(w_unused_stall[4]), .o_fwd_ok(w_fwd_mrt_w));

    // Combine comparisons into stall and priority-ordered forwarding selects
    always_comb begin
        stall    = w_stl_rs_e | w_stl_rs_m | w_stl_rt_e | w_stl_rt_m;

        fwd_d_rs = FWD_RF;
        if (w_fwd_rs_e)      fwd_d_rs = FWD_E;
        else if (w_fwd_rs_m) fwd_d_rs = FWD_M;

        fwd_d_rt = FWD_RF;
        if (w_fwd_rt_e)      fwd_d_rt = FWD_E;
        else if (w_fwd_rt_m) fwd_d_rt = FWD_M;

        fwd_e_rs = FWD_PIPE;
        if (w_fwd_ers_m)      fwd_e_rs = FWD_M;
        else if (w_fwd_ers_w) fwd_e_rs = FWD_W;

        fwd_e_rt = FWD_PIPE;
        if (w_fwd_ert_m)      fwd_e_rt = FWD_M;
        else if (w_fwd_ert_w) fwd_e_rt = FWD_W;

        fwd_m_rt = w_fwd_mrt_w;
    end

    assign stall_cnt = r_stall_cnt;

    // Advance stage shadows; a stall injects a bubble into E only
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_e         <= '0;
            r_m         <= '0;
            r_w_dst     <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (stall) begin
                r_e <= '0;
                if (r_stall_cnt != 32'hFFFF_FFFF) r_stall_cnt <= r_stall_cnt + 32'd1;
            end else begin
                r_e <= '{dst: d_dst, tnew: d_tnew, rs: d_rs, rt: d_rt};
            end
            r_m     <= '{dst: r_e.dst, tnew: tnew_dec(r_e.tnew), rt: r_e.rt};
            r_w_dst <= r_m.dst;
        end
    end

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker: expected output records are queued as
// each instruction is presented to D and checked mid-cycle.
module tb_hazard_tracker;

    localparam logic [3:0] NONE = 4'hF;

    logic        clk;
    logic        reset;
    logic [4:0]  d_rs, d_rt, d_dst;
    logic [3:0]  d_tuse_rs, d_tuse_rt, d_tnew;
    logic        stall;
    logic [1:0]  fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
    logic        fwd_m_rt;
    logic [31:0] stall_cnt;

    hazard_tracker dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_dst(d_dst), .d_tnew(d_tnew),
        .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
        .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        stall;
        logic [1:0]  fdrs, fdrt, fers, fert;
        logic        fmrt;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_cnt = 0;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [3:0] trs, input logic [3:0] trt,
                         input logic [4:0] dst, input logic [3:0] tnew);
        d_rs = rs; d_rt = rt; d_tuse_rs = trs; d_tuse_rt = trt; d_dst = dst; d_tnew = tnew;
    endtask

    // Queue expectations for the current cycle; a stalled cycle bumps the
    // counter expected from the next cycle on.
    task automatic push(input string tag, input logic st, input logic [1:0] fdrs,
                        input logic [1:0] fdrt, input logic [1:0] fers,
                        input logic [1:0] fert, input logic fmrt);
        exp_t e;
        e.tag = tag; e.stall = st; e.fdrs = fdrs; e.fdrt = fdrt;
        e.fers = fers; e.fert = fert; e.fmrt = fmrt; e.cnt = exp_cnt;
        sb.push_back(e);
        if (st) exp_cnt++;
    endtask

    task automatic check_front();
        exp_t e;
        if (sb.size() == 0) begin
            cmp("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        cmp({e.tag, ".stall"},     {31'd0, stall},    {31'd0, e.stall});
        cmp({e.tag, ".fwd_d_rs"},  {30'd0, fwd_d_rs}, {30'd0, e.fdrs});
        cmp({e.tag, ".fwd_d_rt"},  {30'd0, fwd_d_rt}, {30'd0, e.fdrt});
        cmp({e.tag, ".fwd_e_rs"},  {30'd0, fwd_e_rs}, {30'd0, e.fers});
        cmp({e.tag, ".fwd_e_rt"},  {30'd0, fwd_e_rt}, {30'd0, e.fert});
        cmp({e.tag, ".fwd_m_rt"},  {31'd0, fwd_m_rt}, {31'd0, e.fmrt});
        cmp({e.tag, ".stall_cnt"}, stall_cnt,         e.cnt);
    endtask

    // One pipeline cycle: present D, queue expectations, check mid-cycle,
    // then move just past the next rising edge.
    task automatic step(input string tag,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [3:0] trs, input logic [3:0] trt,
                        input logic [4:0] dst, input logic [3:0] tnew,
                        input logic st, input logic [1:0] fdrs, input logic [1:0] fdrt,
                        input logic [1:0] fers, input logic [1:0] fert, input logic fmrt);
        drive(rs, rt, trs, trt, dst, tnew);
        push(tag, st, fdrs, fdrt, fers, fert, fmrt);
        @(negedge clk);
        check_front();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        drive(5'd0, 5'd0, 4'd0, 4'd0, 5'd0, 4'd0);
        @(posedge clk);
        @(negedge clk);
        push("in_reset", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        check_front();
        #2 reset = 1'b1;
        @(posedge clk);
        #1;

        //    tag          rs    rt    trs   trt   dst   tnew   st    fdrs  fdrt  fers  fert  fmrt
        step("post_reset", 5'd0, 5'd0, 4'd0, 4'd0, 5'd0, 4'd0,  1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        // addu $1 -> beq $1: one stall, then forward from M
        step("addu1",      5'd0, 5'd0, NONE, NONE, 5'd1, 4'd1,  1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        step("beq1_stall", 5'd1, 5'd0, 4'd0, NONE, 5'd0, 4'd0,  1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        step("beq1_fwdm",  5'd1, 5'd0, 4'd0, NONE, 5'd0, 4'd0,  1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0);
        // lw $2 -> addu $2 (tuse 1): one stall; beq's rs=$1 in E sees W
        step("lw2",        5'd0, 5'd0, NONE, NONE, 5'd2, 4'd2,  1'b0, 2'd0, 2'd0, 2'd2, 2'd0, 1'b0);
        step("addu2_stall",5'd2, 5'd0, 4'd1, NONE, 5'd5, 4'd1,  1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        step("addu2_go",   5'd2, 5'd0, 4'd1, NONE, 5'd5, 4'd1,  1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        // addu in E while lw in W: E-side operand comes from W
        step("addu2_in_e", 5'd0, 5'd0, NONE, NONE, 5'd0, 4'd0,  1'b0, 2'd0, 2'd0, 2'd2, 2'd0, 1'b0);
        // lui $3 -> beq rt=$3: no stall, forward from E
        step("lui3",       5'd0, 5'd0, NONE, NONE, 5'd3, 4'd0,  1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        step("beq3",       5'd0, 5'd3, NONE, 4'd0, 5'd0, 4'd0,  1'b0, 2'd0, 2'd2, 2'd0, 2'd0, 1'b0);
        // $0 writer then $0 reader; meanwhile beq rt=$3 in E picks M, then M-rt picks W
        step("wr_r0",      5'd0, 5'd0, NONE, NONE, 5'd0, 4'd2,  1'b0, 2'd0, 2'd0, 2'd0, 2'd1, 1'b0);
        step("rd_r0",      5'd0, 5'd0, 4'd0, 4'd0, 5'd0, 4'd0,  1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);
        // lw $4 -> sw rt=$4 (tuse 2): no stall, store data from W in M
        step("lw4",        5'd0, 5'd0, NONE, NONE, 5'd4, 4'd2,  1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        step("sw4",        5'd0, 5'd4, NONE, 4'd2, 5'd0, 4'd0,  1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        step("sw4_in_e",   5'd0, 5'd0, NONE, NONE, 5'd0, 4'd0,  1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        step("sw4_in_m",   5'd0, 5'd0, NONE, NONE, 5'd0, 4'd0,  1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);
        // lw $6 -> beq $6: two-cycle stall, reset asserted in the second
        step("lw6",        5'd0, 5'd0, NONE, NONE, 5'd6, 4'd2,  1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        step("beq6_st1",   5'd6, 5'd0, 4'd0, NONE, 5'd0, 4'd0,  1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);

        drive(5'd6, 5'd0, 4'd0, NONE, 5'd0, 4'd0);
        push("beq6_st2", 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        @(negedge clk);
        check_front();
        #2 reset = 1'b0;
        #1;
        exp_cnt = 0;
        push("async_rst", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        check_front();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        step("after_rst",  5'd6, 5'd0, 4'd0, NONE, 5'd0, 4'd0,  1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);

        if (sb.size() != 0) cmp("scoreboard_leftover", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
